// File: rtl/serv_dbus_resp_if.sv
// Wishbone-style data-bus bundle between the SERV dbus master and its responder.
interface serv_dbus_resp_if;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_wb_err;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack, o_wb_err
  );
endinterface

// File: rtl/serv_dbus_resp.sv
// Data-bus responder for SERV: word RAM, byte-lane writes, registered reads, WAIT wait states.
// Optional out-of-range error response enabled by defining SERV_DBUS_RESP_ERR_EN.
module serv_dbus_resp #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 0,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  serv_dbus_resp_if.slave  wb,
  output logic             o_busy
);

  localparam int unsigned CW        = 4;
  localparam logic [CW-1:0] WAIT_L  = CW'(WAIT);
  localparam bit          ZERO_WAIT = (WAIT == 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [AW-1:0] r_idx, w_idx;
  logic [31:0]   r_dat, w_dat;
  logic [3:0]    r_sel, w_sel;
  logic          r_we, w_we;
  logic          r_oor, w_oor;
  logic          w_oor_in;
  logic          w_go;
  logic          w_ack, w_err, w_busy;
  logic [31:0]   r_rdt;
  logic          r_ack, r_err, r_busy;
  logic [31:0]   r_mem [DEPTH];

`ifdef SERV_DBUS_RESP_ERR_EN
  assign w_oor_in = |wb.i_wb_adr[31:AW+2];
  logic w_unused;
  assign w_unused = &{1'b0, wb.i_wb_adr[1:0]};
`else
  assign w_oor_in = 1'b0;
  logic w_unused;
  assign w_unused = &{1'b0, wb.i_wb_adr[31:AW+2], wb.i_wb_adr[1:0]};
`endif

  // Next state, request capture and access strobe; w_go marks the edge entering ACK.
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_idx  = r_idx;
    w_dat  = r_dat;
    w_sel  = r_sel;
    w_we   = r_we;
    w_oor  = r_oor;
    w_go   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (wb.i_wb_cyc) begin
          w_idx = wb.i_wb_adr[AW+1:2];
          w_dat = wb.i_wb_dat;
          w_sel = wb.i_wb_sel;
          w_we  = wb.i_wb_we;
          w_oor = w_oor_in;
          w_cnt = WAIT_L;
          if (ZERO_WAIT) begin
            w_next = S_ACK;
            w_go   = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb.i_wb_cyc) begin
          w_next = S_IDLE;
        end else begin
          w_cnt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_next = S_ACK;
            w_go   = 1'b1;
          end
        end
      end
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_ack  = w_go && !w_oor;
    w_err  = w_go && w_oor;
    w_busy = (w_next != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dat   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_dat   <= w_dat;
      r_sel   <= w_sel;
      r_we    <= w_we;
      r_oor   <= w_oor;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_busy  <= w_busy;
      // Out-of-range accesses return zero; writes leave read data untouched.
      if (w_go && (w_oor || !w_we)) begin
        r_rdt <= w_oor ? 32'h0 : r_mem[w_idx];
      end
    end
  end

  // RAM is not reset; the reset gate drops a write racing an asserting reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_go && w_we && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (w_sel[b]) r_mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
      end
    end
  end

  assign wb.o_wb_rdt = r_rdt;
  assign wb.o_wb_ack = r_ack;
  assign wb.o_wb_err = r_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_serv_dbus_resp.sv
// Directed bench for serv_dbus_resp: table of WAIT=0 accesses plus wait-state, abort and reset sequences.
module tb_serv_dbus_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] t_adr, t_dat;
  logic [3:0]  t_sel;
  logic        t_we;
  logic [2:0]  t_cyc;

  logic [2:0]  o_ack, o_err, o_bsy;
  logic [31:0] o_rdt [3];

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic ERR_EN =
`ifdef SERV_DBUS_RESP_ERR_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [31:0] ALIAS_W = ERR_EN ? 32'hCAFEF00D : 32'h0BADBEEF;
  localparam logic [31:0] OOR_RDT = ERR_EN ? 32'h0 : 32'h0BADBEEF;

  always #5 clk = ~clk;

  serv_dbus_resp_if if0 ();
  serv_dbus_resp_if if3 ();
  serv_dbus_resp_if if5 ();

  assign if0.i_wb_adr = t_adr; assign if0.i_wb_dat = t_dat; assign if0.i_wb_sel = t_sel;
  assign if0.i_wb_we  = t_we;  assign if0.i_wb_cyc = t_cyc[0];
  assign if3.i_wb_adr = t_adr; assign if3.i_wb_dat = t_dat; assign if3.i_wb_sel = t_sel;
  assign if3.i_wb_we  = t_we;  assign if3.i_wb_cyc = t_cyc[1];
  assign if5.i_wb_adr = t_adr; assign if5.i_wb_dat = t_dat; assign if5.i_wb_sel = t_sel;
  assign if5.i_wb_we  = t_we;  assign if5.i_wb_cyc = t_cyc[2];

  assign o_ack = {if5.o_wb_ack, if3.o_wb_ack, if0.o_wb_ack};
  assign o_err = {if5.o_wb_err, if3.o_wb_err, if0.o_wb_err};
  assign o_rdt[0] = if0.o_wb_rdt;
  assign o_rdt[1] = if3.o_wb_rdt;
  assign o_rdt[2] = if5.o_wb_rdt;

  serv_dbus_resp #(.DEPTH(256), .WAIT(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .wb(if0.slave), .o_busy(o_bsy[0]));
  serv_dbus_resp #(.DEPTH(256), .WAIT(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .wb(if3.slave), .o_busy(o_bsy[1]));
  serv_dbus_resp #(.DEPTH(256), .WAIT(5)) dut5 (.i_clk(clk), .i_rst_n(rst_n), .wb(if5.slave), .o_busy(o_bsy[2]));

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rdt;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One full request on DUT d; expects ack/err after wt+1 edges and a single-cycle pulse.
  task automatic xact(input int d, input int unsigned wt, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      output logic [31:0] rdt, output logic err);
    int   lat;
    logic done;
    t_we = we; t_adr = adr; t_dat = dat; t_sel = sel;
    t_cyc[d] = 1'b1;
    lat = 0; done = 1'b0; err = 1'b0; rdt = '0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (o_ack[d] || o_err[d]) begin
        done = 1'b1;
        err  = o_err[d];
        rdt  = o_rdt[d];
      end else begin
        check("busy_in_wait", 32'(o_bsy[d]), 32'd1);
      end
    end
    t_cyc[d] = 1'b0;
    check("latency", 32'(lat), 32'(wt + 1));
    check("ack_err_excl", 32'(o_ack[d] & o_err[d]), 32'd0);
    check("busy_at_ack", 32'(o_bsy[d]), 32'd1);
    tick();
    check("pulse_end", 32'({o_ack[d], o_err[d], o_bsy[d]}), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    vec[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
    vec[1]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
    vec[2]  = '{1'b1, 32'h10,  32'h00001200, 4'b0010, 32'h0,        1'b0};
    vec[3]  = '{1'b0, 32'h10,  32'h0,        4'b1111, 32'hDEAD12EF, 1'b0};
    vec[4]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0};
    vec[5]  = '{1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEAD12EF, 1'b0};
    vec[6]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'b1111, 32'h0,        1'b0};
    vec[7]  = '{1'b1, 32'h22,  32'h11223344, 4'b1001, 32'h0,        1'b0};
    vec[8]  = '{1'b0, 32'h21,  32'h0,        4'b0000, 32'h11BBCC44, 1'b0};
    vec[9]  = '{1'b1, 32'h0,   32'hCAFEF00D, 4'b1111, 32'h0,        1'b0};
    vec[10] = '{1'b0, 32'h3FC, 32'h0,        4'b1111, 32'h0,        1'b0};
    vec[11] = '{1'b1, 32'h400, 32'h0BADBEEF, 4'b1111, 32'h0,        ERR_EN};
    vec[12] = '{1'b0, 32'h400, 32'h0,        4'b1111, OOR_RDT,      ERR_EN};
    vec[13] = '{1'b0, 32'h0,   32'h0,        4'b1111, ALIAS_W,      1'b0};

    rst_n = 1'b0; t_cyc = '0; t_adr = '0; t_dat = '0; t_sel = '0; t_we = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check("reset_outs", 32'({o_ack[d], o_err[d], o_bsy[d]}), 32'd0);
      check("reset_rdt", o_rdt[d], 32'h0);
    end
    rst_n = 1'b1;
    tick();

    // Word 0x3FC is written first so vector 10 reads a known value.
    xact(0, 0, 1'b1, 32'h3FC, 32'h0, 4'b1111, rd, er);
    for (int i = 0; i < NV; i++) begin
      xact(0, 0, vec[i].we, vec[i].adr, vec[i].dat, vec[i].sel, rd, er);
      check($sformatf("err_flag[%0d]", i), 32'(er), 32'(vec[i].exp_err));
      if (!vec[i].we) check($sformatf("rdata[%0d]", i), rd, vec[i].exp_rdt);
    end
    check("rdt_hold", o_rdt[0], ALIAS_W);

    // Wait states: WAIT=3 acknowledges on the fourth edge.
    xact(1, 3, 1'b1, 32'h40, 32'h11111111, 4'b1111, rd, er);
    xact(1, 3, 1'b0, 32'h40, 32'h0, 4'b0000, rd, er);
    check("w3_read", rd, 32'h11111111);

    // Abort: cyc dropped during WAIT must leave RAM and ack untouched.
    t_we = 1'b1; t_adr = 32'h40; t_dat = 32'h55; t_sel = 4'b1111; t_cyc[1] = 1'b1;
    tick(); tick();
    check("abort_busy", 32'(o_bsy[1]), 32'd1);
    t_cyc[1] = 1'b0;
    tick();
    check("abort_idle", 32'(o_bsy[1]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("abort_no_ack", 32'({o_ack[1], o_err[1]}), 32'd0);
      tick();
    end
    xact(1, 3, 1'b0, 32'h40, 32'h0, 4'b1111, rd, er);
    check("abort_old_val", rd, 32'h11111111);

    // Reset mid-operation on the WAIT=5 instance.
    xact(2, 5, 1'b1, 32'h80, 32'hA5A5A5A5, 4'b1111, rd, er);
    xact(2, 5, 1'b0, 32'h80, 32'h0, 4'b0000, rd, er);
    check("w5_read", o_rdt[2], 32'hA5A5A5A5);
    t_we = 1'b1; t_adr = 32'h80; t_dat = 32'h12345678; t_sel = 4'b1111; t_cyc[2] = 1'b1;
    tick(); tick();
    check("pre_reset_busy", 32'(o_bsy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'({o_ack[2], o_err[2], o_bsy[2]}), 32'd0);
    check("async_reset_rdt", o_rdt[2], 32'h0);
    t_cyc[2] = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_reset_no_ack", 32'({o_ack[2], o_err[2], o_bsy[2]}), 32'd0);
    end
    xact(2, 5, 1'b0, 32'h80, 32'h0, 4'b1111, rd, er);
    check("reset_ram_kept", rd, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
